// File: rtl/burst_addr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | burst_addr_ctrl                                                          |
// | AXI4 burst address sequencer: command FIFO feeding a FIXED/INCR/WRAP     |
// | beat generator with byte-lane masks and protocol-error flagging.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module burst_addr_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int CMD_DEPTH  = 2
) (
    input  logic                    aclk_i,
    input  logic                    aresetn_i,
    input  logic [ID_WIDTH-1:0]     id_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [2:0]              asize_i,
    input  logic [1:0]              aburst_i,
    input  logic [7:0]              alen_i,
    input  logic                    avalid_i,
    output logic                    aready_o,
    output logic [ID_WIDTH-1:0]     id_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH/8-1:0] lane_mask_o,
    output logic [7:0]              beat_o,
    output logic                    addr_last_o,
    output logic                    err_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i
);
    localparam int c_nb     = DATA_WIDTH / 8;
    localparam int c_log_nb = $clog2(c_nb);
    localparam int c_pw     = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int c_cntw   = $clog2(CMD_DEPTH + 1);
    localparam int c_cw     = ID_WIDTH + ADDR_WIDTH + 13;
    localparam int c_xw     = ADDR_WIDTH + 16;

    localparam logic [1:0] c_fixed = 2'b00;
    localparam logic [1:0] c_incr  = 2'b01;
    localparam logic [1:0] c_wrap  = 2'b10;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    function automatic logic [c_nb-1:0] f_lane_mask(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [2:0]            sz);
        logic [ADDR_WIDTH-1:0] nbm;
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH:0]   lo;
        logic [ADDR_WIDTH:0]   hi;
        nbm  = ADDR_WIDTH'(c_nb - 1);
        step = ADDR_WIDTH'(1) << sz;
        lo   = {1'b0, a & nbm};
        hi   = {1'b0, a & ~(step - 1'b1) & nbm} + {1'b0, step};
        for (int i = 0; i < c_nb; i++) begin
            f_lane_mask[i] = ((ADDR_WIDTH+1)'(i) >= lo) && ((ADDR_WIDTH+1)'(i) < hi);
        end
    endfunction

    function automatic logic [c_pw-1:0] f_ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- command FIFO ----------------
    logic [c_cw-1:0]   r_mem [CMD_DEPTH];
    logic [c_pw-1:0]   r_wptr;
    logic [c_pw-1:0]   r_rptr;
    logic [c_cntw-1:0] r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full   = (r_count == c_cntw'(CMD_DEPTH));
    assign w_empty  = (r_count == '0);
    assign aready_o = ~w_full;
    assign w_push   = avalid_i & ~w_full;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= f_ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= f_ptr_inc(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (w_push) r_mem[r_wptr] <= {id_i, addr_i, asize_i, aburst_i, alen_i};
    end

    // ---------------- head-of-FIFO decode ----------------
    logic [ID_WIDTH-1:0]   w_h_id;
    logic [ADDR_WIDTH-1:0] w_h_addr;
    logic [2:0]            w_h_size;
    logic [1:0]            w_h_burst;
    logic [7:0]            w_h_len;
    logic [7:0]            w_h_incr;
    logic [15:0]           w_h_total;
    logic [11:0]           w_h_align12;
    logic [16:0]           w_h_end;
    logic [c_xw-1:0]       w_h_lower_x;
    logic                  w_h_err;

    assign {w_h_id, w_h_addr, w_h_size, w_h_burst, w_h_len} = r_mem[r_rptr];
    assign w_h_incr    = 8'd1 << w_h_size;
    assign w_h_total   = 16'({1'b0, w_h_len} + 9'd1) << w_h_size;
    assign w_h_align12 = w_h_addr[11:0] & ~{4'b0, w_h_incr - 8'd1};
    // Last byte of an INCR burst; anything past 0xFFF means it left the start page.
    assign w_h_end     = {5'b0, w_h_align12} + {1'b0, w_h_total} - 17'd1;
    assign w_h_lower_x = c_xw'(w_h_addr) & ~(c_xw'(w_h_total) - c_xw'(1));

    always_comb begin
        w_h_err = 1'b0;
        if (w_h_size > 3'(c_log_nb)) w_h_err = 1'b1;
        case (w_h_burst)
            c_fixed: if (w_h_len > 8'd15) w_h_err = 1'b1;
            c_incr:  if (w_h_end > 17'hFFF) w_h_err = 1'b1;
            c_wrap: begin
                if (!(w_h_len == 8'd1 || w_h_len == 8'd3 || w_h_len == 8'd7 || w_h_len == 8'd15))
                    w_h_err = 1'b1;
                if ((w_h_addr[7:0] & (w_h_incr - 8'd1)) != 8'd0) w_h_err = 1'b1;
            end
            default: w_h_err = 1'b1;
        endcase
    end

    // ---------------- beat generator ----------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_load;
    logic                  w_adv;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_nb-1:0]       r_mask;
    logic [7:0]            r_beat;
    logic                  r_last;
    logic                  r_err;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_len;
    logic [ADDR_WIDTH-1:0] r_lower;
    logic [c_xw-1:0]       r_bound;
    logic [7:0]            w_incr;
    logic [11:0]           w_incr_lo;
    logic [c_xw-1:0]       w_sum_x;
    logic [ADDR_WIDTH-1:0] w_next;

    // Loading is the action taken on the edge that leaves IDLE or ends a burst,
    // which is what gives the two-cycle latency and the bubble-free hand-over.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (addr_ready_i) begin
                    if (!r_last)       w_adv       = 1'b1;
                    else if (!w_empty) w_load      = 1'b1;
                    else               w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign w_pop        = w_load;
    assign addr_valid_o = (r_state == S_ACTIVE);

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    assign w_incr    = 8'd1 << r_size;
    assign w_incr_lo = (r_addr[11:0] & ~{4'b0, w_incr - 8'd1}) + {4'b0, w_incr};
    assign w_sum_x   = c_xw'(r_addr) + c_xw'(w_incr);

    always_comb begin
        case (r_burst)
            c_fixed: w_next = r_addr;
            c_wrap:  w_next = (w_sum_x == r_bound) ? r_lower : w_sum_x[ADDR_WIDTH-1:0];
            default: w_next = {r_addr[ADDR_WIDTH-1:12], w_incr_lo};
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_beat  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= '0;
            r_burst <= '0;
            r_len   <= '0;
            r_lower <= '0;
            r_bound <= '0;
        end else if (w_load) begin
            r_id    <= w_h_id;
            r_addr  <= w_h_addr;
            r_mask  <= f_lane_mask(w_h_addr, w_h_size);
            r_beat  <= '0;
            r_last  <= (w_h_len == 8'd0);
            r_err   <= w_h_err;
            r_size  <= w_h_size;
            r_burst <= w_h_burst;
            r_len   <= w_h_len;
            r_lower <= w_h_lower_x[ADDR_WIDTH-1:0];
            r_bound <= w_h_lower_x + c_xw'(w_h_total);
        end else if (w_adv) begin
            r_addr  <= w_next;
            r_mask  <= f_lane_mask(w_next, r_size);
            r_beat  <= r_beat + 8'd1;
            r_last  <= ((r_beat + 8'd1) == r_len);
        end
    end

    assign id_o        = r_id;
    assign addr_o      = r_addr;
    assign lane_mask_o = r_mask;
    assign beat_o      = r_beat;
    assign addr_last_o = r_last;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_addr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_burst_addr_ctrl                                                       |
// | Scoreboard bench for burst_addr_ctrl with a behavioural burst model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_burst_addr_ctrl;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int IW    = 4;
    localparam int DEPTH = 2;
    localparam int NB    = DW / 8;

    logic          clk;
    logic          aresetn;
    logic [IW-1:0] id_in;
    logic [AW-1:0] addr_in;
    logic [2:0]    size_in;
    logic [1:0]    burst_in;
    logic [7:0]    len_in;
    logic          avalid;
    logic          aready;
    logic [IW-1:0] id_o;
    logic [AW-1:0] addr_o;
    logic [NB-1:0] lane_mask_o;
    logic [7:0]    beat_o;
    logic          addr_last_o;
    logic          err_o;
    logic          addr_valid_o;
    logic          addr_ready;

    burst_addr_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CMD_DEPTH(DEPTH)
    ) dut (
        .aclk_i(clk), .aresetn_i(aresetn),
        .id_i(id_in), .addr_i(addr_in), .asize_i(size_in), .aburst_i(burst_in),
        .alen_i(len_in), .avalid_i(avalid), .aready_o(aready),
        .id_o(id_o), .addr_o(addr_o), .lane_mask_o(lane_mask_o), .beat_o(beat_o),
        .addr_last_o(addr_last_o), .err_o(err_o),
        .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [NB-1:0] mask;
        logic [7:0]    beat;
        logic          last;
        logic          err;
    } beat_t;

    beat_t exp_q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [NB-1:0] lane_mask(input longint unsigned a, input logic [2:0] sz);
        longint unsigned bytes, lo, hi;
        bytes = 64'd1 << sz;
        lo = a % NB;
        hi = ((a - (a % bytes)) % NB) + bytes;
        lane_mask = '0;
        for (int i = 0; i < NB; i++)
            if (i >= lo && i < hi) lane_mask[i] = 1'b1;
    endfunction

    // Expands one command into its expected beats straight from the burst rules.
    task automatic model_push(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [2:0] sz,
                              input logic [1:0] bt, input logic [7:0] ln);
        longint unsigned start, bytes, total, aligned, lower, cur, nxt, amask;
        logic  err;
        beat_t b;
        amask   = (64'd1 << AW) - 1;
        start   = a;
        bytes   = 64'd1 << sz;
        total   = (ln + 1) * bytes;
        aligned = start - (start % bytes);
        lower   = start & ~(total - 1);
        err = (bytes > NB) || (bt == 2'b11) ||
              (bt == 2'b10 && !(ln inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              (bt == 2'b10 && (start % bytes) != 0) ||
              (bt == 2'b00 && ln > 15) ||
              (bt == 2'b01 && ((aligned + total - 1) >> 12) != (start >> 12));
        cur = start;
        for (int n = 0; n <= ln; n++) begin
            b.id   = id;
            b.addr = cur[AW-1:0];
            b.mask = lane_mask(cur, sz);
            b.beat = n[7:0];
            b.last = (n == ln);
            b.err  = err;
            exp_q.push_back(b);
            case (bt)
                2'b00:   cur = start;
                2'b10: begin
                    nxt = cur + bytes;
                    cur = (nxt == lower + total) ? lower : (nxt & amask);
                end
                default: cur = (start & ~64'hFFF) | ((aligned + (n + 1) * bytes) & 64'hFFF);
            endcase
        end
    endtask

    task automatic send_cmd(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [7:0] ln);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        id_in = id; addr_in = a; size_in = sz; burst_in = bt; len_in = ln;
        avalid = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            ok = aready;
            @(posedge clk);
        end
        if (ok) model_push(id, a, sz, bt, ln);
        else begin
            n_total++;
            n_bad++;
            $display("FAIL cmd_accept: aready=0 want=1 within budget");
        end
        #1 avalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || addr_valid_o) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ready driver
    initial begin
        addr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       addr_ready = 1'b0;
                1:       addr_ready = 1'b1;
                default: addr_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // monitor: scoreboard pops on every beat handshake, plus stall stability
    initial begin
        beat_t       e;
        logic [54:0] snap, now;
        bit          stall_prev;
        stall_prev = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) stall_prev = 1'b0;
            else begin
                now = {id_o, addr_o, lane_mask_o, beat_o, addr_last_o, err_o, addr_valid_o};
                if (stall_prev) chk("stall_stable", 64'(now), 64'(snap));
                if (addr_valid_o && addr_ready) begin
                    n_total++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL beat: unexpected beat addr=%h beat=%0d, want none", addr_o, beat_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (addr_o !== e.addr || lane_mask_o !== e.mask || beat_o !== e.beat ||
                            addr_last_o !== e.last || err_o !== e.err || id_o !== e.id) begin
                            n_bad++;
                            $display("FAIL beat: got addr=%h mask=%h beat=%0d last=%b err=%b id=%h want addr=%h mask=%h beat=%0d last=%b err=%b id=%h",
                                     addr_o, lane_mask_o, beat_o, addr_last_o, err_o, id_o,
                                     e.addr, e.mask, e.beat, e.last, e.err, e.id);
                        end
                    end
                end
                stall_prev = addr_valid_o && !addr_ready;
                snap = now;
            end
        end
    end

    initial begin
        logic [AW-1:0] ra;
        logic [2:0]    rs;
        logic [1:0]    rb;
        logic [7:0]    rl;
        logic [7:0]    lens [5];
        int            cnt;
        bit            found;

        lens = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15};
        aresetn = 1'b1; avalid = 1'b0; id_in = '0; addr_in = '0;
        size_in = '0; burst_in = '0; len_in = '0;
        #2 aresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_aready", 64'(aready), 64'd1);
        chk("rst_valid",  64'(addr_valid_o), 64'd0);
        chk("rst_last",   64'(addr_last_o), 64'd0);
        chk("rst_err",    64'(err_o), 64'd0);
        chk("rst_addr",   64'(addr_o), 64'd0);
        chk("rst_id",     64'(id_o), 64'd0);
        chk("rst_mask",   64'(lane_mask_o), 64'd0);
        chk("rst_beat",   64'(beat_o), 64'd0);
        aresetn = 1'b1;

        // INCR with two-cycle latency check
        send_cmd(4'd5, 32'h1000_0004, 3'd2, 2'b01, 8'd3);
        @(negedge clk); chk("latency_t1_valid", 64'(addr_valid_o), 64'd0);
        @(negedge clk); chk("latency_t2_valid", 64'(addr_valid_o), 64'd1);
        drain("incr");
        send_cmd(4'd1, 32'h38, 3'd3, 2'b10, 8'd3);   drain("wrap");
        send_cmd(4'd2, 32'h38, 3'd3, 2'b10, 8'd2);   drain("wrap_len2");
        send_cmd(4'd3, 32'h03, 3'd3, 2'b01, 8'd1);   drain("incr_unaligned");
        send_cmd(4'd4, 32'h03, 3'd3, 2'b00, 8'd2);   drain("fixed_unaligned");
        send_cmd(4'd6, 32'h1FF8, 3'd3, 2'b01, 8'd1); drain("page_cross");
        send_cmd(4'd7, 32'h100, 3'd4, 2'b01, 8'd0);  drain("oversize");

        // queueing under stall, then bubble-free release
        rdy_mode = 0;
        @(posedge clk);
        send_cmd(4'd7, 32'h40, 3'd3, 2'b01, 8'd1);
        send_cmd(4'd8, 32'h80, 3'd3, 2'b01, 8'd1);
        send_cmd(4'd9, 32'hC0, 3'd3, 2'b01, 8'd1);
        @(negedge clk); chk("fifo_full_aready", 64'(aready), 64'd0);
        repeat (3) @(negedge clk);
        rdy_mode = 1;
        @(posedge clk);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (addr_valid_o) cnt++;
        end
        chk("stream_no_bubble", 64'(cnt), 64'd6);
        drain("queue");

        // reset in the middle of a burst
        send_cmd(4'd3, 32'h200, 3'd2, 2'b01, 8'd7);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (addr_valid_o && beat_o == 8'd2) found = 1'b1;
        end
        chk("reached_beat2", 64'(found), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_valid",  64'(addr_valid_o), 64'd0);
        chk("midrst_addr",   64'(addr_o), 64'd0);
        chk("midrst_beat",   64'(beat_o), 64'd0);
        chk("midrst_mask",   64'(lane_mask_o), 64'd0);
        chk("midrst_id",     64'(id_o), 64'd0);
        chk("midrst_last_err", 64'({addr_last_o, err_o}), 64'd0);
        chk("midrst_aready", 64'(aready), 64'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        send_cmd(4'd6, 32'h300, 3'd3, 2'b01, 8'd1);
        @(negedge clk); chk("post_rst_t1_valid", 64'(addr_valid_o), 64'd0);
        @(negedge clk); chk("post_rst_t2_valid", 64'(addr_valid_o), 64'd1);
        drain("post_reset");

        // randomized traffic with random backpressure
        rdy_mode = 2;
        for (int c = 0; c < 40; c++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra[11:0] = 12'hFC0 | 12'($urandom_range(0, 63));
            rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : lens[$urandom_range(0, 4)];
            send_cmd(4'($urandom_range(0, 15)), ra, rs, rb, rl);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
        end
        rdy_mode = 1;
        drain("random");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/burst_addr_ctrl.md
# burst_addr_ctrl

Parametrised AXI4 burst address sequencer for the SRAM slave. It accepts AR or AW commands with ID, buffers them in a small command FIFO, and expands each command into one address beat per transfer. FIXED, INCR and WRAP bursts are supported, with per-beat byte-lane masks, 4 KB page containment and protocol-error flagging. It sits between the AXI4 address channel and the SRAM read or write datapath.

## Interface
- `ADDR_WIDTH`, 32: address width in bits (≥13).
- `DATA_WIDTH`, 64: data bus width in bits. Must be a power of two, 8..1024. `NB = DATA_WIDTH/8` byte lanes.
- `ID_WIDTH`, 4: AXI ID width (≥1).
- `CMD_DEPTH`, 2: command FIFO entries. Must be a power of two, ≥1.
- `aclk_i` in 1: clock. Single clock domain.
- `aresetn_i` in 1: reset, asynchronous and active-low.
- `id_i` in `ID_WIDTH`: command ID.
- `addr_i` in `ADDR_WIDTH`: start address.
- `asize_i` in 3: log2 of bytes per beat.
- `aburst_i` in 2: burst type. 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `alen_i` in 8: beats minus 1.
- `avalid_i` in 1, `aready_o` out 1: command handshake.
- `id_o` out `ID_WIDTH`: ID of the current burst.
- `addr_o` out `ADDR_WIDTH`: beat address.
- `lane_mask_o` out `NB`: active byte lanes for this beat.
- `beat_o` out 8: beat index within the burst, starting at 0.
- `addr_last_o` out 1: final beat of the burst.
- `err_o` out 1: current burst is illegal. Held for every beat of that burst.
- `addr_valid_o` out 1, `addr_ready_i` in 1: beat handshake.

## Operation
- **Command FIFO**
  - Push on `avalid_i & aready_o`. `aready_o = ~full`, so there is no push-through when full.
  - Push and pop in the same cycle are both honoured.
- **Generator states**
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD pops the FIFO, registers the command, computes beat 0, then goes to ACTIVE.
  - ACTIVE presents a beat with `addr_valid_o=1`.
  - On a beat handshake (`addr_valid_o & addr_ready_i`) that is not last: advance the beat and stay in ACTIVE.
  - On a last-beat handshake with the FIFO non-empty: pop and load the next command in the same cycle, stay in ACTIVE.
  - On a last-beat handshake with the FIFO empty: go to IDLE.
- **Beat address rules.** `aligned = addr & ~(2^asize-1)`.
  - FIXED: every beat uses the start address unchanged.
  - INCR: beat 0 uses the start address. Beat n uses `aligned + n·2^asize`. Only bits [11:0] change; bits above 11 hold the start page.
  - WRAP: `total = (alen+1)·2^asize`, `lower = addr & ~(total-1)`. The next address is `cur + 2^asize`; if it equals `lower+total`, it becomes `lower`.
- **Lane mask.** For beat address `a`: lane i is set iff `a mod NB ≤ i < (aligned(a) mod NB) + 2^asize`.
- **`err_o` is set** for the whole burst if any of the following holds. Beats are still generated per the rules above; reserved bursts are sequenced as INCR.
  - `2^asize > NB`
  - `aburst_i == 11`
  - WRAP with `alen ∉ {1,3,7,15}`
  - WRAP with an unaligned start address
  - FIXED with `alen > 15`
  - INCR whose last byte (`aligned + total - 1`) lies in a different 4 KB page from the start
- **Arithmetic.** `total` is computed to 12 bits plus carry; page-crossing detection uses the carry.

## Timing
- **Reset values:** `aready_o=1`; `addr_valid_o`, `addr_last_o`, `err_o` = 0; `addr_o`, `id_o`, `lane_mask_o`, `beat_o` = 0. FIFO empty, generator in IDLE.
- **Latency:** a command accepted at cycle T into an empty FIFO with the generator IDLE gives `addr_valid_o=1` at T+2.
- **Back-to-back bursts:** beat 0 of a queued burst is valid the cycle after the previous last-beat handshake. There are zero bubbles.
- **Backpressure:** while `addr_valid_o & ~addr_ready_i`, every output is stable. `addr_ready_i` while `addr_valid_o=0` has no effect.
- **Single-beat burst** (`alen=0`): `addr_last_o=1` on beat 0.
- **Reset mid-burst:** outputs go to reset values immediately (asynchronous), the FIFO is flushed, and in-flight beats are discarded.

## Test plan
- **INCR.** `addr=0x1000_0004`, size 2, len 3, id 5.
  - Addresses: 0x…04, 0x…08, 0x…0C, 0x…10.
  - Masks: 0xF0, 0x0F, 0xF0, 0x0F.
  - `addr_last_o` on beat 3, `id_o=5`, first valid at T+2, `err_o=0`.
- **WRAP.** `addr=0x38`, size 3, len 3.
  - Addresses: 0x38, 0x20, 0x28, 0x30; masks all 0xFF.
  - Also len 2 with the same address: same sequencing rules, `err_o=1`.
- **Unaligned INCR and FIXED.**
  - INCR `addr=0x03`, size 3, len 1: addresses 0x03 (mask 0xF8), 0x08 (mask 0xFF).
  - FIXED `addr=0x03`, size 3, len 2: address 0x03 with mask 0xF8 on all three beats.
- **4 KB crossing and oversize.**
  - INCR `addr=0x1FF8`, size 3, len 1: addresses 0x1FF8, 0x1000; `err_o=1` on both beats.
  - size 4 on a 64-bit bus: `err_o=1`.
- **Queueing.** `CMD_DEPTH=2`, `addr_ready_i=0`.
  - Three commands: `aready_o` drops after the FIFO fills.
  - Outputs stay stable across 3 stall cycles.
  - Release stalls: bursts stream with no idle cycle between the two last→first transitions.
- **Reset mid-burst.** Assert `aresetn_i` on beat 2 of a len-7 burst.
  - All outputs go to zero asynchronously and `aready_o=1`.
  - After release, a new command produces beat 0 at T+2.
